div_arbiter: RTL

Shares one combinational integer divider (`comb_div`) among `NUM_REQ` requesters with round-robin arbitration. The divider is treated as a multicycle path: the operands are held stable for `EXEC_CYCLES` clocks before the result is sampled. The block sits between the FPU front-end clients (mantissa divide, integer DIV/MOD unit) and the divider. It returns the quotient, remainder, divide-by-zero flag and requester ID through a single valid/ready response port.

---
 rtl/div_arb_pkg.sv | 29 ++
 rtl/div_arbiter_if.sv | 33 +++
 rtl/comb_div.sv | 24 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/div_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM states, response
// record and the requester-ID width helper.
package div_arb_pkg;

    localparam int DEF_WIDTH       = 24;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_EXEC_CYCLES = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } div_arb_state_e;

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_WIDTH-1:0] quotient;
        logic [DEF_WIDTH-1:0] remainder;
        logic                 div_zero;
    } div_rsp_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Request/response bundle between the FPU clients and the divider arbiter.
// master = client side, slave = arbiter side.
interface div_arbiter_if import div_arb_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [WIDTH-1:0]              rsp_quotient;
    logic [WIDTH-1:0]              rsp_remainder;
    logic                          rsp_div_zero;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
               rsp_div_zero, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
               rsp_div_zero, busy
    );

endinterface

// File: rtl/comb_div.sv
// Combinational unsigned divider. Divide-by-zero returns all-ones quotient
// and the dividend as remainder. Timed as a multicycle path by its user.
module comb_div #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    // Truncating divide, with the zero-divisor case substituted.
    always_comb begin
        div_zero  = (b == '0);
        quotient  = '1;
        remainder = a;
        if (!div_zero) begin
            quotient  = a / b;
            remainder = a % b;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter import div_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    logic [ID_W-1:0] idx;

    // Scan NUM_REQ positions starting at ptr and keep the first hit.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one combinational divider among NUM_REQ clients with round-robin
// arbitration. Operands are registered on grant and held for EXEC_CYCLES
// clocks before the divider result is captured into the response registers.
//
//   state | meaning
//   IDLE  | arbitrate; accept one request when any is valid
//   EXEC  | operands held, divider settling; exec_cnt 0..EXEC_CYCLES-1
//   RESP  | response presented until rsp_ready
module div_arbiter import div_arb_pkg::*; #(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int EXEC_CYCLES = DEF_EXEC_CYCLES
) (
    input  logic          clk,
    input  logic          rst_n,
    div_arbiter_if.slave  bus
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [ID_W-1:0]  PTR_LAST = ID_W'(NUM_REQ - 1);

    div_arb_state_e     state_q, state_d;
    logic [CNT_W-1:0]   exec_cnt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_next;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [ID_W-1:0]    op_id;

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_quot_q, rsp_rem_q;
    logic               rsp_dz_q;

    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept;
    logic               exec_last;

    logic [WIDTH-1:0]   div_quot, div_rem;
    logic               div_dz;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req          (bus.req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // Fed only from the operand registers so the inputs stay still for EXEC.
    comb_div #(.WIDTH(WIDTH)) u_div (
        .a         (op_a),
        .b         (op_b),
        .quotient  (div_quot),
        .remainder (div_rem),
        .div_zero  (div_dz)
    );

    assign ptr_next = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        exec_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt == CNT_LAST) begin
                    exec_last = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, pointer advance, exec counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            exec_cnt    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_dz_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= bus.req_a[grant_idx];
                op_b   <= bus.req_b[grant_idx];
                op_id  <= grant_idx;
                rr_ptr <= ptr_next;
            end
            if (state_q == EXEC) begin
                exec_cnt <= exec_last ? '0 : exec_cnt + 1'b1;
            end
            if (exec_last) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= op_id;
                rsp_quot_q  <= div_quot;
                rsp_rem_q   <= div_rem;
                rsp_dz_q    <= div_dz;
            end else if (state_q == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Ready only while arbitrating, so rsp_ready never reaches req_ready.
    assign bus.req_ready     = accept ? grant_onehot : '0;
    assign bus.busy          = (state_q != IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_quotient  = rsp_quot_q;
    assign bus.rsp_remainder = rsp_rem_q;
    assign bus.rsp_div_zero  = rsp_dz_q;

endmodule
